// File: rtl/img_pkg.sv
// img_pkg: mode constants, FSM state encoding and pixel-expansion helpers
// shared by the display-mode controller and its configuration registers.
package img_pkg;

   // Display modes, one per processing stage.
   localparam logic [2:0] MODE_RAW   = 3'd0;
   localparam logic [2:0] MODE_GRAY  = 3'd1;
   localparam logic [2:0] MODE_GAUSS = 3'd2;
   localparam logic [2:0] MODE_BIN   = 3'd3;
   localparam logic [2:0] MODE_SOBEL = 3'd4;
   localparam logic [2:0] MODE_LAST  = 3'd4;

   // Output framing FSM states.
   localparam logic [0:0] WAIT_SOP = 1'b0;
   localparam logic [0:0] FRAME    = 1'b1;

   // 8-bit gray to RGB565: replicate the top bits into each channel.
   function automatic logic [15:0] gray_to_rgb565(input logic [7:0] g);
      return {g[7:3], g[7:2], g[7:3]};
   endfunction

   // 1-bit binary pixel to full white / full black.
   function automatic logic [15:0] bin_to_rgb565(input logic b);
      return {16{b}};
   endfunction

endpackage

// File: rtl/img_cfg_regs.sv
// img_cfg_regs: pending and committed display mode / binarisation threshold.
// Key pulses update the pending copies every cycle; i_commit copies pending
// into the committed outputs (only asserted between frames by the top level).
module img_cfg_regs
   import img_pkg::*;
#(
   parameter int THR_INIT = 128,
   parameter int THR_STEP = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_key_mode,
   input  logic       i_key_up,
   input  logic       i_key_dn,
   input  logic       i_commit,
   output logic [2:0] o_mode,
   output logic [7:0] o_bin_thr
);

   logic [2:0] r_pend_mode;
   logic [7:0] r_pend_thr;
   logic [2:0] r_mode;
   logic [7:0] r_thr;

   logic [8:0] w_thr_up;
   logic [8:0] w_thr_dn;
   logic [2:0] w_mode_next;

   // Next pending values: mode wraps after the last stage, threshold saturates.
   always_comb begin
      // NOTE: every signal gets a value before any condition so no latch is inferred.
      w_thr_up    = {1'b0, r_pend_thr} + 9'(THR_STEP);
      w_thr_dn    = {1'b0, r_pend_thr} - 9'(THR_STEP);
      w_mode_next = r_pend_mode + 3'd1;
      if (w_thr_up > 9'd255) begin
         w_thr_up = 9'd255;
      end
      if ({1'b0, r_pend_thr} < 9'(THR_STEP)) begin
         w_thr_dn = 9'd0;
      end
      if (r_pend_mode >= MODE_LAST) begin
         w_mode_next = MODE_RAW;
      end
   end

   // Pending registers follow the keys every cycle, independent of framing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_mode <= MODE_RAW;
         r_pend_thr  <= 8'(THR_INIT);
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (i_key_mode) begin
            r_pend_mode <= w_mode_next;
         end
         if (i_key_up && !i_key_dn) begin
            r_pend_thr <= w_thr_up[7:0];
         end else if (i_key_dn && !i_key_up) begin
            r_pend_thr <= w_thr_dn[7:0];
         end
      end
   end

   // Committed registers take the pending values only when strobed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode <= MODE_RAW;
         r_thr  <= 8'(THR_INIT);
      end else if (i_commit) begin
         r_mode <= r_pend_mode;
         r_thr  <= r_pend_thr;
      end
   end

   assign o_mode    = r_mode;
   assign o_bin_thr = r_thr;

endmodule

// File: rtl/img_mode_ctrl.sv
// img_mode_ctrl: frame-synchronous display-mode controller. Selects one stage
// stream by the committed mode, converts it to RGB565 and forwards it with one
// cycle of latency. Mode/threshold commits happen only between output frames;
// a watchdog aborts a frame whose selected stream stalls for TIMEOUT cycles.
// Optional build macro IMG_FRAME_STAT_EN adds frame_cnt and drop_cnt outputs.
module img_mode_ctrl
   import img_pkg::*;
#(
   parameter int THR_INIT = 128,
   parameter int THR_STEP = 8,
   parameter int TIMEOUT  = 2**20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_mode,
   input  logic        key_up,
   input  logic        key_dn,
   input  logic [15:0] s0_din,
   input  logic        s0_vld,
   input  logic        s0_sop,
   input  logic        s0_eop,
   input  logic [7:0]  s1_din,
   input  logic        s1_vld,
   input  logic        s1_sop,
   input  logic        s1_eop,
   input  logic [7:0]  s2_din,
   input  logic        s2_vld,
   input  logic        s2_sop,
   input  logic        s2_eop,
   input  logic        s3_din,
   input  logic        s3_vld,
   input  logic        s3_sop,
   input  logic        s3_eop,
   input  logic        s4_din,
   input  logic        s4_vld,
   input  logic        s4_sop,
   input  logic        s4_eop,
   output logic [7:0]  bin_thr,
   output logic [2:0]  mode,
   output logic [15:0] dout,
   output logic        dout_vld,
   output logic        dout_sop,
   output logic        dout_eop,
`ifdef IMG_FRAME_STAT_EN
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt,
`endif
   output logic        err_timeout
);

   logic [0:0]  r_state;
   logic [23:0] r_wd_cnt;
   logic [15:0] r_dout;
   logic        r_vld;
   logic        r_sop;
   logic        r_eop;
   logic        r_err;

   logic        w_sel_vld;
   logic        w_sel_sop;
   logic        w_sel_eop;
   logic [15:0] w_sel_pix;
   logic        w_sop_hit;
   logic        w_commit;
   logic        w_fwd;
   logic        w_timeout;

   img_cfg_regs #(
      .THR_INIT (THR_INIT),
      .THR_STEP (THR_STEP)
   ) u_cfg (
      .clk        (clk),
      .rst        (rst),
      .i_key_mode (key_mode),
      .i_key_up   (key_up),
      .i_key_dn   (key_dn),
      .i_commit   (w_commit),
      .o_mode     (mode),
      .o_bin_thr  (bin_thr)
   );

   // Stream select by committed mode, pixel already expanded to RGB565;
   // unused encodings fall back to the raw stream.
   always_comb begin
      w_sel_vld = s0_vld;
      w_sel_sop = s0_sop;
      w_sel_eop = s0_eop;
      w_sel_pix = s0_din;
      case (mode)
         MODE_GRAY: begin
            w_sel_vld = s1_vld;
            w_sel_sop = s1_sop;
            w_sel_eop = s1_eop;
            w_sel_pix = gray_to_rgb565(s1_din);
         end
         MODE_GAUSS: begin
            w_sel_vld = s2_vld;
            w_sel_sop = s2_sop;
            w_sel_eop = s2_eop;
            w_sel_pix = gray_to_rgb565(s2_din);
         end
         MODE_BIN: begin
            w_sel_vld = s3_vld;
            w_sel_sop = s3_sop;
            w_sel_eop = s3_eop;
            w_sel_pix = bin_to_rgb565(s3_din);
         end
         MODE_SOBEL: begin
            w_sel_vld = s4_vld;
            w_sel_sop = s4_sop;
            w_sel_eop = s4_eop;
            w_sel_pix = bin_to_rgb565(s4_din);
         end
         default: begin
         end
      endcase
   end

   // A sop beat in WAIT_SOP both starts the frame and blocks the commit, so
   // the frame is processed with the values committed before it.
   assign w_sop_hit = w_sel_vld & w_sel_sop;
   assign w_commit  = (r_state == WAIT_SOP) & ~w_sop_hit;
   assign w_fwd     = (r_state == WAIT_SOP) ? w_sop_hit : w_sel_vld;
   assign w_timeout = (r_state == FRAME) & ~w_sel_vld
                    & (r_wd_cnt == 24'(TIMEOUT - 1));

   // Framing FSM and stall watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= WAIT_SOP;
         r_wd_cnt <= '0;
      end else begin
         if (w_fwd || w_timeout || (r_state == WAIT_SOP)) begin
            r_wd_cnt <= '0;
         end else begin
            r_wd_cnt <= r_wd_cnt + 24'd1;
         end
         case (r_state)
            WAIT_SOP: if (w_sop_hit && !w_sel_eop) r_state <= FRAME;
            FRAME:    if (w_timeout || (w_sel_vld && w_sel_eop)) r_state <= WAIT_SOP;
         endcase
      end
   end

   // Output register: one cycle of latency, data held while not valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout <= '0;
         r_vld  <= 1'b0;
         r_sop  <= 1'b0;
         r_eop  <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_vld <= w_fwd;
         r_sop <= w_fwd & w_sel_sop;
         r_eop <= w_fwd & w_sel_eop;
         r_err <= w_timeout;
         if (w_fwd) begin
            r_dout <= w_sel_pix;
         end
      end
   end

   assign dout        = r_dout;
   assign dout_vld    = r_vld;
   assign dout_sop    = r_sop;
   assign dout_eop    = r_eop;
   assign err_timeout = r_err;

`ifdef IMG_FRAME_STAT_EN
   logic [15:0] r_frame_cnt;
   logic [15:0] r_drop_cnt;
   logic        w_frame_done;
   logic        w_drop;

   assign w_frame_done = (r_state == FRAME) & w_sel_vld & w_sel_eop;
   assign w_drop       = w_timeout | ((r_state == FRAME) & w_sop_hit);

   // Completed-frame counter wraps; drop counter saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_img_mode_ctrl.sv
// tb_img_mode_ctrl: directed scenarios followed by randomized frame traffic,
// every cycle compared against a cycle-level behavioural model of the
// controller. Runs with a short watchdog (TIMEOUT=16).
module tb_img_mode_ctrl;

   localparam int THR_INIT = 128;
   localparam int THR_STEP = 8;
   localparam int TIMEOUT  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_mode, key_up, key_dn;
   logic [15:0] s0_din;
   logic        s0_vld, s0_sop, s0_eop;
   logic [7:0]  s1_din;
   logic        s1_vld, s1_sop, s1_eop;
   logic [7:0]  s2_din;
   logic        s2_vld, s2_sop, s2_eop;
   logic        s3_din;
   logic        s3_vld, s3_sop, s3_eop;
   logic        s4_din;
   logic        s4_vld, s4_sop, s4_eop;
   logic [7:0]  bin_thr;
   logic [2:0]  mode;
   logic [15:0] dout;
   logic        dout_vld, dout_sop, dout_eop;
   logic        err_timeout;
`ifdef IMG_FRAME_STAT_EN
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;
`endif

   img_mode_ctrl #(
      .THR_INIT (THR_INIT),
      .THR_STEP (THR_STEP),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk (clk), .rst (rst),
      .key_mode (key_mode), .key_up (key_up), .key_dn (key_dn),
      .s0_din (s0_din), .s0_vld (s0_vld), .s0_sop (s0_sop), .s0_eop (s0_eop),
      .s1_din (s1_din), .s1_vld (s1_vld), .s1_sop (s1_sop), .s1_eop (s1_eop),
      .s2_din (s2_din), .s2_vld (s2_vld), .s2_sop (s2_sop), .s2_eop (s2_eop),
      .s3_din (s3_din), .s3_vld (s3_vld), .s3_sop (s3_sop), .s3_eop (s3_eop),
      .s4_din (s4_din), .s4_vld (s4_vld), .s4_sop (s4_sop), .s4_eop (s4_eop),
      .bin_thr (bin_thr), .mode (mode),
      .dout (dout), .dout_vld (dout_vld), .dout_sop (dout_sop), .dout_eop (dout_eop),
`ifdef IMG_FRAME_STAT_EN
      .frame_cnt (frame_cnt), .drop_cnt (drop_cnt),
`endif
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   int          m_pmode, m_pthr, m_cmode, m_cthr, m_idle;
   bit          m_in_frame;
   logic [15:0] e_dout;
   bit          e_vld, e_sop, e_eop, e_err;

   // Observed-output tallies for the directed scenarios.
   int n_vld_seen, n_sop_seen, n_eop_seen, n_err_seen, err_at;
   int tick_no;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] gray_exp(input logic [7:0] g);
      int r5 = int'(g) / 8;
      int g6 = int'(g) / 4;
      return 16'(r5 * 2048 + g6 * 32 + r5);
   endfunction

   task automatic model_reset();
      m_pmode = 0; m_pthr = THR_INIT; m_cmode = 0; m_cthr = THR_INIT;
      m_idle = 0; m_in_frame = 0;
      e_dout = 16'h0; e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0;
   endtask

   // Predict the outputs after the coming clock edge from the current inputs.
   task automatic model_step();
      logic [15:0] px [5];
      bit v [5];
      bit s [5];
      bit e [5];
      int m;
      bit sop_hit, commit_now;
      px[0] = s0_din;
      px[1] = gray_exp(s1_din);
      px[2] = gray_exp(s2_din);
      px[3] = s3_din ? 16'hFFFF : 16'h0000;
      px[4] = s4_din ? 16'hFFFF : 16'h0000;
      v[0] = s0_vld; v[1] = s1_vld; v[2] = s2_vld; v[3] = s3_vld; v[4] = s4_vld;
      s[0] = s0_sop; s[1] = s1_sop; s[2] = s2_sop; s[3] = s3_sop; s[4] = s4_sop;
      e[0] = s0_eop; e[1] = s1_eop; e[2] = s2_eop; e[3] = s3_eop; e[4] = s4_eop;
      m = (m_cmode > 4) ? 0 : m_cmode;
      sop_hit    = v[m] && s[m];
      commit_now = !m_in_frame && !sop_hit;
      e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0;
      if (!m_in_frame) begin
         if (sop_hit) begin
            e_vld = 1; e_sop = 1; e_eop = e[m]; e_dout = px[m];
            m_in_frame = !e[m];
            m_idle = 0;
         end
      end else if (v[m]) begin
         e_vld = 1; e_sop = s[m]; e_eop = e[m]; e_dout = px[m];
         m_idle = 0;
         if (e[m]) m_in_frame = 0;
      end else begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            e_err = 1; m_in_frame = 0; m_idle = 0;
         end
      end
      if (commit_now) begin
         m_cmode = m_pmode;
         m_cthr  = m_pthr;
      end
      if (key_mode) m_pmode = (m_pmode + 1) % 5;
      if (key_up && !key_dn) m_pthr = (m_pthr + THR_STEP > 255) ? 255 : m_pthr + THR_STEP;
      if (key_dn && !key_up) m_pthr = (m_pthr - THR_STEP < 0) ? 0 : m_pthr - THR_STEP;
   endtask

   // One clock: model, edge, compare, then clear the single-cycle inputs.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      tick_no++;
      check("dout",        32'(dout),        32'(e_dout));
      check("dout_vld",    32'(dout_vld),    32'(e_vld));
      check("dout_sop",    32'(dout_sop),    32'(e_sop));
      check("dout_eop",    32'(dout_eop),    32'(e_eop));
      check("err_timeout", 32'(err_timeout), 32'(e_err));
      check("mode",        32'(mode),        32'(m_cmode));
      check("bin_thr",     32'(bin_thr),     32'(m_cthr));
      n_vld_seen += int'(dout_vld);
      n_sop_seen += int'(dout_sop);
      n_eop_seen += int'(dout_eop);
      if (err_timeout) begin
         n_err_seen++;
         err_at = tick_no;
      end
      @(negedge clk);
      key_mode = 0; key_up = 0; key_dn = 0;
      {s0_vld, s0_sop, s0_eop} = 3'b000;
      {s1_vld, s1_sop, s1_eop} = 3'b000;
      {s2_vld, s2_sop, s2_eop} = 3'b000;
      {s3_vld, s3_sop, s3_eop} = 3'b000;
      {s4_vld, s4_sop, s4_eop} = 3'b000;
   endtask

   // All stages carry the same framing; data is fixed-pattern or random.
   task automatic drive(input bit v, input bit s, input bit e, input bit fixed, input int idx);
      {s0_vld, s0_sop, s0_eop} = {v, s, e};
      {s1_vld, s1_sop, s1_eop} = {v, s, e};
      {s2_vld, s2_sop, s2_eop} = {v, s, e};
      {s3_vld, s3_sop, s3_eop} = {v, s, e};
      {s4_vld, s4_sop, s4_eop} = {v, s, e};
      if (fixed) begin
         s0_din = 16'h1234;
         s1_din = 8'hFF;
         s2_din = 8'hFF;
         s3_din = ~idx[0];
         s4_din = ~idx[0];
      end else begin
         s0_din = 16'($urandom);
         s1_din = 8'($urandom);
         s2_din = 8'($urandom);
         s3_din = 1'($urandom);
         s4_din = 1'($urandom);
      end
   endtask

   task automatic send_frame(input int n, input bit fixed, input int key_beat);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, i == 0, i == n - 1, fixed, i);
         if (i == key_beat) key_mode = 1;
         tick();
      end
   endtask

   task automatic clear_tallies();
      n_vld_seen = 0; n_sop_seen = 0; n_eop_seen = 0; n_err_seen = 0;
      err_at = -1; tick_no = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_mode"},  32'(mode),        32'd0);
      check({tag, "_thr"},   32'(bin_thr),     32'(THR_INIT));
      check({tag, "_dout"},  32'(dout),        32'd0);
      check({tag, "_flags"}, 32'({dout_vld, dout_sop, dout_eop, err_timeout}), 32'd0);
   endtask

   int rem, stall;

   initial begin
      rst = 1;
      key_mode = 0; key_up = 0; key_dn = 0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
      model_reset();
      clear_tallies();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 0;
      @(negedge clk);

      // Two 8-beat raw frames pass through unchanged.
      clear_tallies();
      send_frame(8, 1'b1, -1);
      tick();
      send_frame(8, 1'b1, -1);
      check("raw_sop_count", 32'(n_sop_seen), 32'd2);
      check("raw_eop_count", 32'(n_eop_seen), 32'd2);
      check("raw_beats",     32'(n_vld_seen), 32'd16);
      check("raw_dout",      32'(dout),       32'h1234);

      // key_mode mid-frame only takes effect once the frame has ended.
      send_frame(8, 1'b1, 3);
      check("mode_frozen", 32'(mode), 32'd0);
      clear_tallies();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, i);
         tick();
      end
      check("partial_dropped", 32'(n_vld_seen), 32'd0);
      check("mode_gray", 32'(mode), 32'd1);
      send_frame(8, 1'b1, -1);
      check("gray_white", 32'(dout), 32'hFFFF);

      // Threshold stepping and saturation.
      repeat (5) begin key_up = 1; tick(); end
      tick();
      check("thr_168", 32'(bin_thr), 32'd168);
      repeat (20) begin key_up = 1; tick(); end
      tick();
      check("thr_max", 32'(bin_thr), 32'd255);
      repeat (40) begin key_dn = 1; tick(); end
      tick();
      check("thr_min", 32'(bin_thr), 32'd0);

      // Binary mode: alternating pixels.
      key_mode = 1; tick();
      key_mode = 1; tick();
      tick();
      check("mode_bin", 32'(mode), 32'd3);
      send_frame(8, 1'b1, -1);
      check("bin_last_black", 32'(dout), 32'h0000);

      // Watchdog abort after TIMEOUT idle cycles.
      clear_tallies();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
      tick();
      for (int i = 0; i < 20; i++) tick();
      check("to_pulses", 32'(n_err_seen), 32'd1);
      check("to_cycle",  32'(err_at),     32'(TIMEOUT + 1));
      check("to_no_eop", 32'(n_eop_seen), 32'd0);
`ifdef IMG_FRAME_STAT_EN
      check("to_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

      // key_mode in the sop cycle: this frame keeps the old mode.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 0);
      key_mode = 1;
      tick();
      for (int i = 1; i < 6; i++) begin
         drive(1'b1, 1'b0, i == 5, 1'b1, i);
         tick();
         check("sop_key_frozen", 32'(mode), 32'd3);
      end
      tick();
      check("sop_key_next", 32'(mode), 32'd4);
      send_frame(4, 1'b1, -1);

      // Randomized traffic with keys, stalls, truncations and a mid-run reset.
      rem = 0; stall = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst = 1;
            #1;
            check_reset_values("midreset");
            model_reset();
            rem = 0; stall = 0;
            @(negedge clk);
            rst = 0;
         end
         if (stall > 0) begin
            stall--;
         end else if (rem == 0) begin
            if ($urandom_range(2) == 0) begin
               rem = $urandom_range(10, 1);
               drive(1'b1, 1'b1, rem == 1, 1'b0, 0);
               rem--;
            end
         end else if ($urandom_range(59) == 0) begin
            stall = TIMEOUT + 4;
         end else if ($urandom_range(39) == 0) begin
            rem = 0;
         end else if ($urandom_range(3) != 0) begin
            drive(1'b1, 1'b0, rem == 1, 1'b0, 0);
            rem--;
         end
         if ($urandom_range(24) == 0) key_mode = 1;
         if ($urandom_range(9) == 0)  key_up = 1;
         if ($urandom_range(9) == 0)  key_dn = 1;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
